expr_sig_collector: RTL and testbench

EXPR_SIG_COLLECTOR -- requirements
Module: expr_sig_collector

---
 rtl/expr_sig_collector.sv | 121 ++++++++++++
 tb/tb_expr_sig_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_sig_collector.sv
// expr_sig_collector: compacts a run of 90-bit expression results into a
// 32-bit MISR signature, counting accepted vectors until VEC_COUNT is reached.
// Optional golden-signature compare (golden/pass/fail ports) is built in when
// the macro EXPR_SIG_CMP_EN is defined; the default build leaves it out.
module expr_sig_collector #(
    parameter int          VEC_COUNT = 256,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] SEED      = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [89:0] in_y,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] count,
    output logic [31:0] signature
`ifdef EXPR_SIG_CMP_EN
    ,
    input  logic [31:0] golden,
    output logic        pass,
    output logic        fail
`endif
);

    // Count value whose accept completes the run.
    localparam logic [15:0] LAST_CNT = 16'(VEC_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        run_start;
    logic [31:0] sig_nxt;
    logic [15:0] cnt_nxt;

    // XOR-fold of the 90-bit result down to the 32-bit MISR input width.
    function automatic logic [31:0] fold(input logic [89:0] y);
        return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    endfunction

    // One MISR shift with polynomial feedback and parallel data injection.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    assign accept    = in_valid && in_ready;
    assign run_start = start && (state != RUN);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start leaves IDLE/DONE, the final accept ends the run.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (accept && (count == LAST_CNT)) state_nxt = DONE;
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (state == RUN);
        in_ready = (state == RUN);
        done     = (state == DONE);
    end

    // Next signature/count: reload on start, fold in one vector per accept, else hold.
    always_comb begin
        sig_nxt = signature;
        cnt_nxt = count;
        if (run_start) begin
            sig_nxt = SEED;
            cnt_nxt = 16'd0;
        end else if (accept) begin
            sig_nxt = misr_step(signature, fold(in_y));
            cnt_nxt = count + 16'd1;
        end
    end

    // Signature and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            signature <= SEED;
            count     <= 16'd0;
        end else begin
            signature <= sig_nxt;
            count     <= cnt_nxt;
        end
    end

`ifdef EXPR_SIG_CMP_EN
    // Verdict registers track the signature entering DONE, so they are valid with done and clear on start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            pass <= (state_nxt == DONE) && (sig_nxt == golden);
            fail <= (state_nxt == DONE) && (sig_nxt != golden);
        end
    end
`endif

endmodule

// File: tb/tb_expr_sig_collector.sv
// Self-checking bench for expr_sig_collector. Four instances with different
// SEED/VEC_COUNT share in_valid/in_y/reset_n and each has its own start.
module tb_expr_sig_collector;

    localparam logic [31:0] POLY_C = 32'h04C11DB7;
    localparam logic [31:0] SEEDS [4] = '{32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF};
    localparam int          VCS   [4] = '{1, 2, 1, 8};

    logic        clk;
    logic        reset_n;
    logic [3:0]  start_v;
    logic        in_valid;
    logic [89:0] in_y;
    logic [3:0]  rdy, bsy, dn;
    logic [15:0] cnt [4];
    logic [31:0] sig [4];
`ifdef EXPR_SIG_CMP_EN
    logic [31:0] golden;
    logic [3:0]  pass_v, fail_v;
`endif

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] sig;
        logic [15:0] cnt;
        logic        run;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] m_sig [4];
    logic [15:0] m_cnt [4];
    logic        m_run [4];

    expr_sig_collector #(.VEC_COUNT(1), .POLY(POLY_C), .SEED(32'h0)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .in_valid(in_valid), .in_y(in_y),
        .in_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .count(cnt[0]), .signature(sig[0])
`ifdef EXPR_SIG_CMP_EN
        , .golden(golden), .pass(pass_v[0]), .fail(fail_v[0])
`endif
    );
    expr_sig_collector #(.VEC_COUNT(2), .POLY(POLY_C), .SEED(32'h0)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .in_valid(in_valid), .in_y(in_y),
        .in_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .count(cnt[1]), .signature(sig[1])
`ifdef EXPR_SIG_CMP_EN
        , .golden(golden), .pass(pass_v[1]), .fail(fail_v[1])
`endif
    );
    expr_sig_collector #(.VEC_COUNT(1), .POLY(POLY_C), .SEED(32'h80000000)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .in_valid(in_valid), .in_y(in_y),
        .in_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .count(cnt[2]), .signature(sig[2])
`ifdef EXPR_SIG_CMP_EN
        , .golden(golden), .pass(pass_v[2]), .fail(fail_v[2])
`endif
    );
    expr_sig_collector #(.VEC_COUNT(8), .POLY(POLY_C), .SEED(32'hFFFFFFFF)) u3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[3]), .in_valid(in_valid), .in_y(in_y),
        .in_ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .count(cnt[3]), .signature(sig[3])
`ifdef EXPR_SIG_CMP_EN
        , .golden(golden), .pass(pass_v[3]), .fail(fail_v[3])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MISR step: bit i of the vector lands on signature bit i mod 32.
    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ POLY_C;
        for (int i = 0; i < 90; i++) r[i % 32] = r[i % 32] ^ y[i];
        return r;
    endfunction

    function automatic logic [89:0] rnd90();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[89:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_sig[k] = SEEDS[k];
            m_cnt[k] = 16'd0;
            m_run[k] = 1'b0;
        end
    endtask

    task automatic do_start(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        if (!m_run[k]) begin
            m_sig[k] = SEEDS[k];
            m_cnt[k] = 16'd0;
            m_run[k] = 1'b1;
        end
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    // Present one vector for one edge and push the expected post-edge state.
    task automatic send(input int k, input logic [89:0] y);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_y     = y;
        if (m_run[k]) begin
            m_sig[k] = model_step(m_sig[k], y);
            m_cnt[k] = m_cnt[k] + 16'd1;
            if (int'(m_cnt[k]) == VCS[k]) m_run[k] = 1'b0;
        end
        e.sig = m_sig[k];
        e.cnt = m_cnt[k];
        e.run = m_run[k];
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (sig[k] !== SEEDS[k]) begin errors++; $display("FAIL reset_sig[%0d]: got %h want %h", k, sig[k], SEEDS[k]); end
            vectors++; if (cnt[k] !== 16'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d want 0", k, cnt[k]); end
        end
        vectors++; if ({bsy, dn, rdy} !== 12'h0) begin errors++; $display("FAIL reset_ctl: got %h want 000", {bsy, dn, rdy}); end
`ifdef EXPR_SIG_CMP_EN
        vectors++; if ({pass_v, fail_v} !== 8'h0) begin errors++; $display("FAIL reset_pf: got %h want 00", {pass_v, fail_v}); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({bsy, rdy} !== 8'h0) begin errors++; $display("FAIL idle_after_reset: got %h want 00", {bsy, rdy}); end
    endtask

    task automatic test_single();
        exp_t e;
        do_start(0);
        vectors++; if ({bsy[0], rdy[0], dn[0]} !== 3'b110) begin errors++; $display("FAIL single_run_ctl: got %b want 110", {bsy[0], rdy[0], dn[0]}); end
        vectors++; if (sig[0] !== 32'h0 || cnt[0] !== 16'd0) begin errors++; $display("FAIL single_load: got %h/%0d want 0/0", sig[0], cnt[0]); end
        send(0, 90'h1);
        e = sb.pop_front();
        vectors++; if (sig[0] !== 32'h1 || sig[0] !== e.sig) begin errors++; $display("FAIL single_sig: got %h want 00000001", sig[0]); end
        vectors++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt[0]); end
        vectors++; if ({dn[0], rdy[0], bsy[0]} !== 3'b100) begin errors++; $display("FAIL single_done: got %b want 100", {dn[0], rdy[0], bsy[0]}); end
    endtask

    task automatic test_fold_cancel();
        logic [89:0] y;
        exp_t e;
        y = (90'h1 << 64) | 90'h1;
        do_start(0);
        vectors++; if (sig[0] !== 32'h0 || cnt[0] !== 16'd0 || bsy[0] !== 1'b1) begin errors++; $display("FAIL fold_restart: got %h/%0d/%b want 0/0/1", sig[0], cnt[0], bsy[0]); end
        send(0, y);
        e = sb.pop_front();
        vectors++; if (sig[0] !== 32'h0 || sig[0] !== e.sig) begin errors++; $display("FAIL fold_sig: got %h want 00000000", sig[0]); end
        vectors++; if (cnt[0] !== 16'd1 || dn[0] !== 1'b1) begin errors++; $display("FAIL fold_done: got %0d/%b want 1/1", cnt[0], dn[0]); end
    endtask

    task automatic test_two_vectors();
        exp_t e;
`ifdef EXPR_SIG_CMP_EN
        golden = 32'h3;
`endif
        do_start(1);
        send(1, 90'h1);
        e = sb.pop_front();
        vectors++; if (sig[1] !== 32'h1 || cnt[1] !== 16'd1) begin errors++; $display("FAIL two_first: got %h/%0d want 1/1", sig[1], cnt[1]); end
        vectors++; if (dn[1] !== 1'b0 || rdy[1] !== e.run) begin errors++; $display("FAIL two_first_ctl: got %b%b want 01", dn[1], rdy[1]); end
        send(1, 90'h1);
        e = sb.pop_front();
        vectors++; if (sig[1] !== 32'h3 || sig[1] !== e.sig) begin errors++; $display("FAIL two_sig: got %h want 00000003", sig[1]); end
        vectors++; if (cnt[1] !== 16'd2 || dn[1] !== 1'b1) begin errors++; $display("FAIL two_done: got %0d/%b want 2/1", cnt[1], dn[1]); end
`ifdef EXPR_SIG_CMP_EN
        vectors++; if (pass_v[1] !== 1'b1 || fail_v[1] !== 1'b0) begin errors++; $display("FAIL cmp_pass: got %b%b want 10", pass_v[1], fail_v[1]); end
        golden = 32'h5;
        @(posedge clk); #1;
        vectors++; if (pass_v[1] !== 1'b0 || fail_v[1] !== 1'b1) begin errors++; $display("FAIL cmp_fail: got %b%b want 01", pass_v[1], fail_v[1]); end
        do_start(1);
        vectors++; if (pass_v[1] !== 1'b0 || fail_v[1] !== 1'b0) begin errors++; $display("FAIL cmp_clear: got %b%b want 00", pass_v[1], fail_v[1]); end
        send(1, 90'h1);
        e = sb.pop_front();
        send(1, 90'h1);
        e = sb.pop_front();
        vectors++; if (pass_v[1] !== 1'b0 || fail_v[1] !== 1'b1) begin errors++; $display("FAIL cmp_fail_run: got %b%b want 01", pass_v[1], fail_v[1]); end
`endif
    endtask

    task automatic test_poly();
        exp_t e;
        do_start(2);
        vectors++; if (sig[2] !== 32'h80000000) begin errors++; $display("FAIL poly_seed: got %h want 80000000", sig[2]); end
        send(2, 90'h0);
        e = sb.pop_front();
        vectors++; if (sig[2] !== 32'h04C11DB7 || sig[2] !== e.sig) begin errors++; $display("FAIL poly_sig: got %h want 04c11db7", sig[2]); end
        vectors++; if (dn[2] !== 1'b1 || cnt[2] !== 16'd1) begin errors++; $display("FAIL poly_done: got %b/%0d want 1/1", dn[2], cnt[2]); end
    endtask

    task automatic test_stall_restart();
        exp_t e;
        do_start(3);
        for (int i = 0; i < 2; i++) begin
            send(3, rnd90());
            e = sb.pop_front();
            vectors++; if (sig[3] !== e.sig || cnt[3] !== e.cnt) begin errors++; $display("FAIL stall_pre%0d: got %h/%0d want %h/%0d", i, sig[3], cnt[3], e.sig, e.cnt); end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_y = rnd90();
            @(posedge clk); #1;
            vectors++; if (sig[3] !== m_sig[3] || cnt[3] !== m_cnt[3]) begin errors++; $display("FAIL stall_hold%0d: got %h/%0d want %h/%0d", i, sig[3], cnt[3], m_sig[3], m_cnt[3]); end
        end
        do_start(3);
        vectors++; if (sig[3] !== m_sig[3] || cnt[3] !== 16'd2 || bsy[3] !== 1'b1) begin errors++; $display("FAIL start_in_run: got %h/%0d/%b want %h/2/1", sig[3], cnt[3], bsy[3], m_sig[3]); end
        for (int i = 0; i < 6; i++) begin
            send(3, rnd90());
            e = sb.pop_front();
            vectors++; if (sig[3] !== e.sig || cnt[3] !== e.cnt) begin errors++; $display("FAIL stall_post%0d: got %h/%0d want %h/%0d", i, sig[3], cnt[3], e.sig, e.cnt); end
            vectors++; if (dn[3] !== (e.cnt == 16'd8) || bsy[3] !== e.run) begin errors++; $display("FAIL stall_ctl%0d: got %b%b want %b%b", i, dn[3], bsy[3], e.cnt == 16'd8, e.run); end
        end
        send(3, rnd90());
        e = sb.pop_front();
        vectors++; if (sig[3] !== e.sig || cnt[3] !== 16'd8 || dn[3] !== 1'b1) begin errors++; $display("FAIL done_hold: got %h/%0d/%b want %h/8/1", sig[3], cnt[3], dn[3], e.sig); end
        do_start(3);
        vectors++; if (sig[3] !== 32'hFFFFFFFF || cnt[3] !== 16'd0 || bsy[3] !== 1'b1) begin errors++; $display("FAIL restart: got %h/%0d/%b want ffffffff/0/1", sig[3], cnt[3], bsy[3]); end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(3, rnd90());
            e = sb.pop_front();
            vectors++; if (sig[3] !== e.sig || cnt[3] !== e.cnt) begin errors++; $display("FAIL b2b%0d: got %h/%0d want %h/%0d", i, sig[3], cnt[3], e.sig, e.cnt); end
        end
        vectors++; if (cnt[3] !== 16'd3 || bsy[3] !== 1'b1) begin errors++; $display("FAIL pre_abort: got %0d/%b want 3/1", cnt[3], bsy[3]); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (sig[3] !== 32'hFFFFFFFF || cnt[3] !== 16'd0) begin errors++; $display("FAIL abort_sig: got %h/%0d want ffffffff/0", sig[3], cnt[3]); end
        vectors++; if ({bsy[3], rdy[3], dn[3]} !== 3'b000) begin errors++; $display("FAIL abort_ctl: got %b want 000", {bsy[3], rdy[3], dn[3]}); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send(3, rnd90());
        e = sb.pop_front();
        vectors++; if (sig[3] !== e.sig || cnt[3] !== 16'd0 || bsy[3] !== 1'b0) begin errors++; $display("FAIL idle_no_accept: got %h/%0d/%b want %h/0/0", sig[3], cnt[3], bsy[3], e.sig); end
    endtask

    initial begin
        reset_n  = 1'b0;
        start_v  = 4'h0;
        in_valid = 1'b0;
        in_y     = '0;
`ifdef EXPR_SIG_CMP_EN
        golden   = 32'h0;
`endif
        model_reset();
        test_reset();
        test_single();
        test_fold_cancel();
        test_two_vectors();
        test_poly();
        test_stall_restart();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
